// File: rtl/clkdiv_frac.sv
// ============================================================================
// clkdiv_frac : fractional clock divider, period div_i + div_f/2^m clk cycles.
// Optional strb output when CLKDIV_FRAC_STRB_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module clkdiv_frac #(
  parameter int n = 8,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] div_i,
  input  logic [m-1:0] div_f,
  output logic         out,
  output logic         reset
`ifdef CLKDIV_FRAC_STRB_EN
  ,
  output logic         strb
`endif
);

  logic [n-1:0] div_i_q, div_i_d;
  logic [m-1:0] div_f_q, div_f_d;
  logic [m-1:0] acc_q, acc_d;
  logic [n:0]   p_q, p_d;
  logic [n:0]   cnt_q, cnt_d;
  logic [n:0]   hi_q, hi_d;
  logic         out_q, out_d;
  logic         reset_q, reset_d;

  logic         start;
  logic         changed;
  logic [m-1:0] acc_base;
  logic [m:0]   sum;
  logic [n:0]   p_new;
  logic [n:0]   cnt_inc;

  always_comb begin
    div_i_d  = div_i_q;
    div_f_d  = div_f_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    out_d    = out_q;
    reset_d  = reset_q;

    // p_q == 0 marks the idle counter; otherwise start on the last cycle
    start    = (p_q == '0) || (cnt_q == (p_q - (n+1)'(1)));
    changed  = {div_i, div_f} != {div_i_q, div_f_q};
    acc_base = changed ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {1'b0, div_f};
    p_new    = {1'b0, div_i} + {{n{1'b0}}, sum[m]};
    cnt_inc  = cnt_q + (n+1)'(1);

    if (start) begin
      div_i_d = div_i;
      div_f_d = div_f;
      reset_d = changed;
      cnt_d   = '0;
      if (div_i == '0) begin
        p_d   = '0;
        hi_d  = '0;
        out_d = 1'b0;
        acc_d = acc_base;
      end else begin
        p_d   = p_new;
        hi_d  = (p_new + (n+1)'(1)) >> 1;
        out_d = 1'b1;
        acc_d = sum[m-1:0];
      end
    end else begin
      cnt_d = cnt_inc;
      out_d = cnt_inc < hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_i_q <= '0;
      div_f_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      out_q   <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      div_i_q <= div_i_d;
      div_f_q <= div_f_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      out_q   <= out_d;
      reset_q <= reset_d;
    end
  end

  assign out   = out_q;
  assign reset = reset_q;

`ifdef CLKDIV_FRAC_STRB_EN
  logic strb_q, strb_d;

  // Registered alongside out, so strb is high in the first high cycle of out
  always_comb begin
    strb_d = out_d & ~out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_q <= 1'b0;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign strb = strb_q;
`else
  // No strobe output in this build.
`endif

endmodule

`default_nettype wire

// File: doc/clkdiv_frac.md
CLKDIV_FRAC -- requirements
Module: clkdiv_frac

Interface
REQ-001 SHALL have parameter n, default 8: width of the integer part of the divider ratio.
REQ-002 SHALL have parameter m, default 4: width of the fractional part of the divider ratio, in units of 1/2^m.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its posedge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port div_i  input  n: integer part of the divider ratio.
REQ-006 SHALL have port div_f  input  m: fractional part of the divider ratio.
REQ-007 SHALL have port out  output  1: divided clock, registered.
REQ-008 SHALL have port reset  output  1: high while the ratio transition is in progress.

Function
REQ-009 SHALL produce an average out period of div_i + div_f/2^m clk cycles, using an m-bit phase accumulator acc.
REQ-010 At each period start, SHALL update {carry, acc} <= acc + latched div_f, and SHALL set period length P = latched div_i + carry.
REQ-011 SHALL drive out high for the first ceil(P/2) clk edges of a period and low for the remaining floor(P/2) edges.
REQ-012 SHALL align the out rising edge to the clk edge that starts the period, with no glitches, because out is a flop output.
REQ-013 SHALL sample div_i/div_f only at a period start (last cycle of a period, or idle); a mid-period change SHALL NOT alter the running period.
REQ-014 When the sampled {div_i,div_f} differs from the latched value, SHALL assert reset from that period-start edge through the end of the first complete period run with the new ratio, then deassert it.
REQ-015 On a ratio change, SHALL clear acc to 0.
REQ-016 div_i == 0 SHALL put the block in idle: out = 0, acc held, counter idle, div re-sampled every clk; the first nonzero value SHALL start a period on the next clk edge.
REQ-017 div_i == 1 with div_f == 0 SHALL hold out constant at 1 (P = 1).
REQ-018 div_i == 1 with div_f != 0 SHALL mix P = 1 periods (out 1) and P = 2 periods (out 1,0).
REQ-019 The period counter SHALL be n+1 bits so that P = 2^n - 1 + 1 does not wrap.
REQ-020 If acc overflows and the ratio changes at the same boundary, the ratio change SHALL take precedence: acc is cleared and carry is discarded.

Reset
REQ-021 With rst_n low at a clk edge, SHALL set out = 0, reset = 0, acc = 0, the counter to idle and the latched ratio to 0; this applies mid-period too.
REQ-022 On the first edge with rst_n high, SHALL sample the div inputs as a period start; a nonzero ratio SHALL count as a change (reset asserted).

Configuration
REQ-023 Macro CLKDIV_FRAC_STRB_EN defined: SHALL add output port strb (1 bit), a one-clk-cycle pulse high on each edge where out rises, usable as a clock enable; strb SHALL be 0 in reset and while idle.
REQ-024 Macro CLKDIV_FRAC_STRB_EN undefined: the strb port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-025 SHALL cover: div_i=4, div_f=0 -> out repeats 1,1,0,0; period 4.
REQ-026 SHALL cover: div_i=3, div_f=8 (m=4), from reset -> periods 3,4,3,4...; out 1,1,0 / 1,1,0,0; average 3.5.
REQ-027 SHALL cover: div_i=0 for 10 cycles -> out=0 throughout; set div_i=5 -> out rises on the next edge, then 1,1,1,0,0 repeats.
REQ-028 SHALL cover: div_i=4 to 6 at the 2nd cycle of a period -> that period completes as 4 cycles, then 6-cycle periods; reset is high from the boundary through the end of the first 6-cycle period.
REQ-029 SHALL cover: rst_n low for 1 edge mid-period with div_i=7 -> out=0 at that edge, acc=0; a new 7-cycle period starts on the following edge with reset high.
REQ-030 SHALL cover: with CLKDIV_FRAC_STRB_EN, div_i=2, div_f=4 -> strb pulses exactly once per out rising edge; pulse spacing is 2,2,2,3 (m=4, acc steps 4/16).
